// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and byte-lane helpers for the data-memory responder
// Purpose : array geometry, store-buffer entry layout, lane extract / extend / byte-merge helpers.
// Ports   : none (package).
// Config  : DMEM_COALESCE_EN is consumed by dmem_sbuf, not here.
package dmem_pkg;

   localparam int         DMEM_DEPTH = 1024;
   localparam int         DMEM_AW    = 10;
   localparam logic [3:0] BE_WORD    = 4'hF;

   typedef struct packed {
      logic [DMEM_AW-1:0] idx;
      logic [31:0]        data;
      logic [3:0]         be;
   } sb_entry_t;

   // Little-endian lane k of a word.
   function automatic logic [7:0] get_lane(input logic [31:0] word, input logic [1:0] k);
      logic [7:0] b;
      case (k)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

   function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sign_ext);
      return sign_ext ? {{24{b[7]}}, b} : {24'h0, b};
   endfunction

   // Overlay the enabled bytes of new_word onto old_word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old_word;
      if (be[0]) r[7:0]   = new_word[7:0];
      if (be[1]) r[15:8]  = new_word[15:8];
      if (be[2]) r[23:16] = new_word[23:16];
      if (be[3]) r[31:24] = new_word[31:24];
      return r;
   endfunction

endpackage

// File: rtl/dmem_sbuf.sv
// rtl/dmem_sbuf.sv - circular store buffer with parallel index-compare load merge
// Purpose : posts CPU stores (head/tail/count FIFO), presents the head for draining and
//           overlays every matching entry (oldest->newest) onto a caller-supplied array word.
// Ports   : i_clk, i_rst (async, active high)
//           i_push/i_push_entry  - enqueue a store
//           i_pop                - drain the head this cycle (ignored when empty)
//           i_query_idx/word     - word index and array word for the load view
//           o_merged             - array word overlaid with buffered bytes
//           o_head/o_empty/o_count
// Config  : DMEM_COALESCE_EN - a store hitting the youngest entry merges into it.
import dmem_pkg::*;

module dmem_sbuf #(
   parameter  int SB_DEPTH = 4,
   localparam int PW       = $clog2(SB_DEPTH),
   localparam int CW       = $clog2(SB_DEPTH + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_push,
   input  sb_entry_t          i_push_entry,
   input  logic               i_pop,
   input  logic [DMEM_AW-1:0] i_query_idx,
   input  logic [31:0]        i_query_word,
   output logic [31:0]        o_merged,
   output sb_entry_t          o_head,
   output logic               o_empty,
   output logic [CW-1:0]      o_count
);

   sb_entry_t     r_mem [SB_DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic w_do_pop;
   logic w_do_enq;
   logic w_merge;

   assign w_do_pop = i_pop && (r_count != '0);

`ifdef DMEM_COALESCE_EN
   logic [PW-1:0] w_young;
   assign w_young = (r_tail == '0) ? PW'(SB_DEPTH - 1) : r_tail - 1'b1;
   // When the only entry is draining this cycle it is the head, not a merge target.
   assign w_merge = i_push && (r_count != '0) && (r_mem[w_young].idx == i_push_entry.idx)
                 && !(w_do_pop && r_count == CW'(1));
`else
   assign w_merge = 1'b0;
`endif

   assign w_do_enq = i_push && !w_merge;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_enq)
            r_tail <= (r_tail == PW'(SB_DEPTH - 1)) ? '0 : r_tail + 1'b1;
         if (w_do_pop)
            r_head <= (r_head == PW'(SB_DEPTH - 1)) ? '0 : r_head + 1'b1;
         case ({w_do_enq, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage needs no reset: slots outside [head, head+count) are never observed.
   always_ff @(posedge i_clk) begin
      if (w_do_enq) begin
         r_mem[r_tail] <= i_push_entry;
      end
`ifdef DMEM_COALESCE_EN
      else if (w_merge) begin
         r_mem[w_young].data <= merge_bytes(r_mem[w_young].data, i_push_entry.data, i_push_entry.be);
         r_mem[w_young].be   <= r_mem[w_young].be | i_push_entry.be;
      end
`endif
   end

   // Overlay walks from head so younger stores win per byte.
   always_comb begin
      o_merged = i_query_word;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (i < int'(r_count) &&
             r_mem[PW'((int'(r_head) + i) % SB_DEPTH)].idx == i_query_idx)
            o_merged = merge_bytes(o_merged,
                                   r_mem[PW'((int'(r_head) + i) % SB_DEPTH)].data,
                                   r_mem[PW'((int'(r_head) + i) % SB_DEPTH)].be);
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst)
         assert (!(w_do_enq && !w_do_pop && r_count == CW'(SB_DEPTH)));
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data memory with posted store buffer and ext port
// Purpose : same-cycle lw/lb/lbu loads over array+buffer, posted sw/sb stores, and a
//           debug/DMA ext port sharing the single array write port with buffer drain.
// Ports   : i_clk, i_rst (async, active high)
//           i_wren, i_sb, i_lb, i_lbu, i_data_address, i_write_data -> o_read_data (comb)
//           i_ext_valid, i_ext_we, i_ext_addr, i_ext_wdata -> o_ext_ready, o_ext_rdata (next cycle)
//           o_sb_count - occupied store-buffer entries
// Config  : DMEM_COALESCE_EN (see dmem_sbuf).
import dmem_pkg::*;

module dmem_responder #(
   parameter  int SB_DEPTH = 4,
   localparam int CW       = $clog2(SB_DEPTH + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_wren,
   input  logic               i_sb,
   input  logic               i_lb,
   input  logic               i_lbu,
   input  logic [31:0]        i_data_address,
   input  logic [31:0]        i_write_data,
   output logic [31:0]        o_read_data,
   input  logic               i_ext_valid,
   input  logic               i_ext_we,
   input  logic [DMEM_AW-1:0] i_ext_addr,
   input  logic [31:0]        i_ext_wdata,
   output logic               o_ext_ready,
   output logic [31:0]        o_ext_rdata,
   output logic [CW-1:0]      o_sb_count
);

   logic [31:0]        r_mem [DMEM_DEPTH];
   logic [31:0]        r_ext_rdata;

   logic [DMEM_AW-1:0] w_cpu_idx;
   logic [1:0]         w_lane;
   logic               w_unused_addr;
   sb_entry_t          w_push_entry;
   sb_entry_t          w_head;
   logic               w_empty;
   logic [31:0]        w_merged;
   logic               w_ext_acc;
   logic               w_ext_wr;
   logic               w_drain;

   // Upper address bits wrap onto the array.
   assign w_cpu_idx     = i_data_address[DMEM_AW+1:2];
   assign w_lane        = i_data_address[1:0];
   assign w_unused_addr = ^i_data_address[31:DMEM_AW+2];

   always_comb begin
      w_push_entry.idx = w_cpu_idx;
      if (i_sb) begin
         w_push_entry.data = {4{i_write_data[7:0]}};
         w_push_entry.be   = 4'b0001 << w_lane;
      end else begin
         w_push_entry.data = i_write_data;
         w_push_entry.be   = BE_WORD;
      end
   end

   // Buffer can only grow while ext owns the write port, so ready stops one short of full.
   assign o_ext_ready = !i_rst && (o_sb_count < CW'(SB_DEPTH - 1));
   assign w_ext_acc   = i_ext_valid && o_ext_ready;
   assign w_ext_wr    = w_ext_acc && i_ext_we;
   assign w_drain     = !w_empty && !w_ext_wr;

   dmem_sbuf #(.SB_DEPTH(SB_DEPTH)) u_sbuf (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_push       (i_wren),
      .i_push_entry (w_push_entry),
      .i_pop        (w_drain),
      .i_query_idx  (w_cpu_idx),
      .i_query_word (r_mem[w_cpu_idx]),
      .o_merged     (w_merged),
      .o_head       (w_head),
      .o_empty      (w_empty),
      .o_count      (o_sb_count)
   );

   // Array contents survive reset; during reset the buffer is empty and ext is not ready.
   always_ff @(posedge i_clk) begin
      if (w_ext_wr)
         r_mem[i_ext_addr] <= i_ext_wdata;
      else if (w_drain)
         r_mem[w_head.idx] <= merge_bytes(r_mem[w_head.idx], w_head.data, w_head.be);
   end

   // Ext reads see the array only, never the buffer.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_ext_rdata <= '0;
      else if (w_ext_acc && !i_ext_we)
         r_ext_rdata <= r_mem[i_ext_addr];
   end

   assign o_ext_rdata = r_ext_rdata;

   always_comb begin
      if (i_lb)
         o_read_data = extend_byte(get_lane(w_merged, w_lane), 1'b1);
      else if (i_lbu)
         o_read_data = extend_byte(get_lane(w_merged, w_lane), 1'b0);
      else
         o_read_data = w_merged;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench with a queue-based reference model
// Purpose : drives directed scenarios then random CPU/ext traffic and compares every cycle.
// Ports   : none (top-level bench).
// Config  : DMEM_COALESCE_EN changes the expected buffer occupancy.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int SBD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wren, sb, lb, lbu;
   logic [31:0] addr, wdata;
   logic [31:0] read_data;
   logic        ext_valid, ext_we;
   logic [9:0]  ext_addr;
   logic [31:0] ext_wdata;
   logic        ext_ready;
   logic [31:0] ext_rdata;
   logic [2:0]  sb_count;

   always #5 clk = ~clk;

   dmem_responder #(.SB_DEPTH(SBD)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_wren         (wren),
      .i_sb           (sb),
      .i_lb           (lb),
      .i_lbu          (lbu),
      .i_data_address (addr),
      .i_write_data   (wdata),
      .o_read_data    (read_data),
      .i_ext_valid    (ext_valid),
      .i_ext_we       (ext_we),
      .i_ext_addr     (ext_addr),
      .i_ext_wdata    (ext_wdata),
      .o_ext_ready    (ext_ready),
      .o_ext_rdata    (ext_rdata),
      .o_sb_count     (sb_count)
   );

   int total = 0;
   int bad   = 0;
   bit checking = 0;
   bit rd_check = 0;

   typedef struct {
      int         idx;
      logic [31:0] data;
      logic [3:0]  be;
   } ment_t;

   logic [31:0] m_mem [1024];
   ment_t       q[$];
   logic [31:0] m_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] put_bytes(input logic [31:0] w, input logic [31:0] d,
                                             input logic [3:0] be);
      logic [31:0] r;
      r = w;
      for (int k = 0; k < 4; k++)
         if (be[k]) r[8*k +: 8] = d[8*k +: 8];
      return r;
   endfunction

   // What a load sees: array word, then every pending store to that word in program order.
   function automatic logic [31:0] model_word(input int idx);
      logic [31:0] w;
      w = m_mem[idx];
      foreach (q[i])
         if (q[i].idx == idx) w = put_bytes(w, q[i].data, q[i].be);
      return w;
   endfunction

   always @(posedge rst) begin
      q.delete();
      m_rdata = 32'h0;
   end

   always @(posedge clk) begin
      if (!rst) begin
         bit    acc;
         ment_t e;
         acc = ext_valid && (q.size() < SBD - 1);
         if (acc && !ext_we) m_rdata = m_mem[ext_addr];
         if (acc && ext_we) begin
            m_mem[ext_addr] = ext_wdata;
         end else if (q.size() > 0) begin
            m_mem[q[0].idx] = put_bytes(m_mem[q[0].idx], q[0].data, q[0].be);
            void'(q.pop_front());
         end
         if (wren) begin
            e.idx  = int'(addr[11:2]);
            e.data = sb ? {4{wdata[7:0]}} : wdata;
            e.be   = sb ? 4'(1 << addr[1:0]) : 4'hF;
`ifdef DMEM_COALESCE_EN
            if (q.size() > 0 && q[$].idx == e.idx) begin
               q[$].data = put_bytes(q[$].data, e.data, e.be);
               q[$].be   = q[$].be | e.be;
            end else
               q.push_back(e);
`else
            q.push_back(e);
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         logic [31:0] w;
         logic [7:0]  b;
         logic [31:0] exp_rd;
         check("sb_count", 32'(sb_count), rst ? 32'd0 : 32'(q.size()));
         check("ext_ready", 32'(ext_ready), 32'(!rst && q.size() < SBD - 1));
         check("ext_rdata", ext_rdata, m_rdata);
         if (rd_check) begin
            w = model_word(int'(addr[11:2]));
            b = w[8*addr[1:0] +: 8];
            exp_rd = lb ? {{24{b[7]}}, b} : (lbu ? {24'h0, b} : w);
            check("read_data", read_data, exp_rd);
         end
      end
   end

   task automatic idle();
      wren = 0; sb = 0; lb = 0; lbu = 0;
      ext_valid = 0; ext_we = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic cpu(input bit w, input bit s, input bit l_b, input bit l_bu,
                      input logic [31:0] a, input logic [31:0] d);
      wren = w; sb = s; lb = l_b; lbu = l_bu; addr = a; wdata = d;
   endtask

   task automatic ext(input bit v, input bit we, input logic [9:0] a, input logic [31:0] d);
      ext_valid = v; ext_we = we; ext_addr = a; ext_wdata = d;
   endtask

   initial begin
      rst = 1; idle(); addr = 0; wdata = 0; ext_addr = 0; ext_wdata = 0;
      #1 checking = 1;
      @(negedge clk);
      check("rst_sb_count", 32'(sb_count), 32'd0);
      check("rst_ext_ready", 32'(ext_ready), 32'd0);
      check("rst_ext_rdata", ext_rdata, 32'd0);
      tick();
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         ext(1, 1, 10'(i), $urandom);
         tick();
      end
      idle();
      tick();
      rd_check = 1;

      // store then load the following cycle
      cpu(1, 0, 0, 0, 32'h10, 32'h11223344); tick();
      cpu(0, 0, 0, 0, 32'h10, 32'h0);
      @(negedge clk); check("t1_lw", read_data, 32'h11223344);
      tick();

      // byte overlay on a buffered word
      cpu(1, 0, 0, 0, 32'h10, 32'h11223344); tick();
      cpu(1, 1, 0, 0, 32'h12, 32'hABCDEF80); tick();
      cpu(0, 0, 1, 0, 32'h12, 32'h0);
      @(negedge clk); check("t2_lb", read_data, 32'hFFFFFF80);
      cpu(0, 0, 0, 1, 32'h12, 32'h0); #1;
      check("t2_lbu", read_data, 32'h00000080);
      cpu(0, 0, 0, 0, 32'h10, 32'h0); #1;
      check("t2_lw", read_data, 32'h11803344);
      tick(); tick(); tick(); tick();

      // ext write lands before an older buffered store drains over it
      cpu(1, 0, 0, 0, 32'h10, 32'h55555555); tick();
      cpu(0, 0, 0, 0, 32'h10, 32'h0);
      ext(1, 1, 10'd4, 32'hAAAAAAAA);
      @(negedge clk); check("t4_lw_buf", read_data, 32'h55555555);
      tick();
      idle(); tick();
      ext(1, 0, 10'd4, 32'h0); tick();
      idle();
      @(negedge clk); check("t4_ext_rd", ext_rdata, 32'h55555555);
      tick();

      // ext holds the port while the CPU stores every cycle
      for (int i = 0; i < 3; i++) begin
         cpu(1, 0, 0, 0, 32'(i * 4), 32'hC0DE0000 + 32'(i));
         ext(1, 1, 10'd6, $urandom);
         tick();
      end
      cpu(0, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      check("t3_ready_low", 32'(ext_ready), 32'd0);
      check("t3_count_full", 32'(sb_count), 32'd3);
      tick();
      @(negedge clk); check("t3_count_dec", 32'(sb_count), 32'd2);
      for (int i = 0; i < 3; i++) begin
         cpu(1, 0, 0, 0, 32'(8 + i * 4), 32'hBEEF0000 + 32'(i));
         tick();
      end

      // reset with entries still pending
      idle();
      ext(1, 0, 10'd4, 32'h0); tick();
      for (int i = 0; i < 3; i++) begin
         cpu(1, 0, 0, 0, 32'(16 + i * 4), 32'hD00D0000 + 32'(i));
         ext(1, 1, 10'd7, $urandom);
         tick();
      end
      idle();
      rst = 1; #1;
      check("t5_count_rst", 32'(sb_count), 32'd0);
      check("t5_rdata_rst", ext_rdata, 32'd0);
      tick();
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         cpu(0, 0, 0, 0, 32'(i * 4), 32'h0);
         tick();
      end

      // consecutive byte stores to one word while drain is blocked
      for (int k = 0; k < 3; k++) begin
         cpu(1, 1, 0, 0, 32'h14 + 32'(k), 32'(8'h60 + k));
         ext(1, 1, 10'd0, $urandom);
         tick();
      end
      idle();
      @(negedge clk);
`ifdef DMEM_COALESCE_EN
      check("t6_count", 32'(sb_count), 32'd1);
`else
      check("t6_count", 32'(sb_count), 32'd3);
`endif
      tick();

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         int mode;
         mode = int'($urandom_range(0, 2));
         cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mode == 1, mode == 2,
             {$urandom_range(0, 32'hFFFFF) , 7'h0, 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3))} , $urandom);
         ext(($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
             10'($urandom_range(0, 7)), $urandom);
         if ($urandom_range(0, 299) == 0) begin
            rst = 1;
            tick();
            rst = 0;
         end else
            tick();
      end

      idle();
      tick();
      checking = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
